ofifo_psum: RTL and testbench

//  Output FIFO directly downstream of the MAC array. It captures each column's out_s psum

---
 rtl/ofifo_psum_pkg.sv | 14 +
 rtl/ofifo_psum_if.sv | 27 ++
 rtl/ofifo_col.sv | 58 +++++
 rtl/ofifo_psum.sv | 76 +++++++
 tb/tb_ofifo_psum.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofifo_psum_pkg.sv
// Shared defaults and pointer sizing for the MAC-array output FIFO.
// Imported by the column FIFO and by the top-level row FIFO.
package ofifo_psum_pkg;

  localparam int unsigned ColDefault    = 8;
  localparam int unsigned PsumBwDefault = 16;
  localparam int unsigned DepthDefault  = 64;

  // Index bits plus one wrap bit, so equal indices can be told apart as full or empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofifo_psum_if.sv
// Bus bundle between the MAC array / consumer and the output FIFO.
// The master drives the psum bus, strobes and pops; the slave is the FIFO.
interface ofifo_psum_if #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16
);

  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_full;
  logic                   o_ovf;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_ready, o_full, o_ovf
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_ready, o_full, o_ovf
  );

endinterface

// File: rtl/ofifo_col.sv
// One column FIFO: storage, write pointer and full/empty against the shared read pointer.
// The read pointer and pop strobe come from the top so all columns stay row-aligned.
module ofifo_col
  import ofifo_psum_pkg::*;
#(
  parameter int unsigned psum_bw = PsumBwDefault,
  parameter int unsigned depth   = DepthDefault
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [psum_bw-1:0]            din,
  input  logic                          wr,
  input  logic                          pop,
  input  logic [ptr_width(depth)-1:0]   rptr,
  output logic [psum_bw-1:0]            dout,
  output logic                          empty,
  output logic                          full,
  output logic                          wr_drop
);

  localparam int unsigned PtrW = ptr_width(depth);
  localparam int unsigned IdxW = PtrW - 1;

  logic [PtrW-1:0]    wptr_q, wptr_d;
  logic [psum_bw-1:0] mem_q [depth];
  logic               wr_ok;

  assign empty = (wptr_q == rptr);
  assign full  = (wptr_q[IdxW-1:0] == rptr[IdxW-1:0]) && (wptr_q[IdxW] != rptr[IdxW]);

  // A pop on the same edge frees a slot, so a full column still accepts the write.
  assign wr_ok   = wr && (!full || pop);
  assign wr_drop = wr && full && !pop;

  always_comb begin
    wptr_d = wptr_q;
    if (wr_ok) begin
      wptr_d = wptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wptr_q[IdxW-1:0]] <= din;
    end
  end

  assign dout = mem_q[rptr[IdxW-1:0]];

endmodule

// File: rtl/ofifo_psum.sv
// Output FIFO behind the MAC array: per-column skewed writes, whole-row registered reads.
// Owns the shared read pointer, the out register and the flag reductions.
module ofifo_psum
  import ofifo_psum_pkg::*;
#(
  parameter int unsigned col     = ColDefault,
  parameter int unsigned psum_bw = PsumBwDefault,
  parameter int unsigned depth   = DepthDefault
) (
  input  logic         clk,
  input  logic         reset,
  ofifo_psum_if.slave  bus
);

  localparam int unsigned PtrW = ptr_width(depth);

  logic [PtrW-1:0]        rptr_q, rptr_d;
  logic [psum_bw*col-1:0] out_q, out_d;
  logic [psum_bw*col-1:0] row;
  logic                   ovf_q, ovf_d;
  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col-1:0]         wr_drop;
  logic                   row_valid;
  logic                   pop;

  for (genvar c = 0; c < col; c++) begin : g_col
    ofifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_col (
      .clk     (clk),
      .reset   (reset),
      .din     (bus.in[c*psum_bw +: psum_bw]),
      .wr      (bus.wr[c]),
      .pop     (pop),
      .rptr    (rptr_q),
      .dout    (row[c*psum_bw +: psum_bw]),
      .empty   (empty[c]),
      .full    (full[c]),
      .wr_drop (wr_drop[c])
    );
  end

  assign row_valid = &(~empty);
  assign pop       = bus.rd && row_valid;

  always_comb begin
    rptr_d = rptr_q;
    out_d  = out_q;
    ovf_d  = ovf_q | (|wr_drop);
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
      out_d  = row;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr_q <= '0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.o_valid = row_valid;
  assign bus.o_full  = |full;
  assign bus.o_ready = ~(|full);
  assign bus.o_ovf   = ovf_q;

endmodule

// File: tb/tb_ofifo_psum.sv
// Randomised bench for ofifo_psum against a queue-per-column reference model.
module tb_ofifo_psum;

  localparam int unsigned COL   = 8;
  localparam int unsigned PW    = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned BW    = COL * PW;

  logic clk;
  logic rst_n;

  ofifo_psum_if #(.col(COL), .psum_bw(PW)) bus ();

  ofifo_psum #(.col(COL), .psum_bw(PW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  logic [PW-1:0] mq [COL][$];
  logic [BW-1:0] exp_out;
  logic          exp_ovf;

  function automatic logic m_valid();
    for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COL; c++) mq[c].delete();
    exp_out = '0;
    exp_ovf = 1'b0;
  endtask

  // Pop happens first, so a write to a full column is admitted when a row is read.
  task automatic model_edge(input logic [COL-1:0] w, input logic r, input logic [BW-1:0] d);
    if (r && m_valid()) begin
      for (int c = 0; c < COL; c++) exp_out[c*PW +: PW] = mq[c].pop_front();
    end
    for (int c = 0; c < COL; c++) begin
      if (w[c]) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(d[c*PW +: PW]);
        else exp_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [BW-1:0] rand_row();
    logic [BW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PW +: PW] = PW'($urandom);
    return r;
  endfunction

  task automatic step(input logic [COL-1:0] w, input logic r, input logic [BW-1:0] d);
    bus.wr = w;
    bus.rd = r;
    bus.in = d;
    @(posedge clk);
    model_edge(w, r, d);
    #1;
  endtask

  task automatic do_reset();
    bus.wr = '0;
    bus.rd = 1'b0;
    bus.in = '0;
    rst_n  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    bus.wr = '1;
    bus.rd = 1'b1;
    bus.in = rand_row();
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (bus.out !== '0 || bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 ||
          bus.o_ovf !== 1'b0 || bus.o_full !== 1'b0) begin
        fails++;
        $display("FAIL reset: out=%h valid=%b ready=%b ovf=%b full=%b, required 0/0/1/0/0",
                 bus.out, bus.o_valid, bus.o_ready, bus.o_ovf, bus.o_full);
      end
    end
    @(negedge clk);
    bus.wr = '0;
    bus.rd = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic test_skewed_fill();
    logic [BW-1:0] d;
    logic [BW-1:0] want;
    do_reset();
    for (int c = 0; c < COL; c++) begin
      d = '0;
      d[c*PW +: PW] = 16'h0100 + PW'(c);
      want[c*PW +: PW] = 16'h0100 + PW'(c);
      step(COL'(1) << c, 1'b0, d);
      tests++;
      if (bus.o_valid !== (c == COL - 1)) begin
        fails++;
        $display("FAIL skew_valid col %0d: got %b, required %b", c, bus.o_valid, c == COL - 1);
      end
    end
    step('0, 1'b1, '0);
    tests++;
    if (bus.out !== want) begin
      fails++;
      $display("FAIL skew_row: got %h, required %h", bus.out, want);
    end
  endtask

  task automatic test_full_ovf();
    logic [BW-1:0] d;
    logic [BW-1:0] want;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      d = '0;
      d[PW-1:0] = PW'(i);
      step(COL'(1), 1'b0, d);
    end
    tests++;
    if (bus.o_full !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_ovf !== 1'b0) begin
      fails++;
      $display("FAIL col0_full: full=%b ready=%b ovf=%b, required 1/0/0",
               bus.o_full, bus.o_ready, bus.o_ovf);
    end
    d = '0;
    d[PW-1:0] = 16'hDEAD;
    step(COL'(1), 1'b0, d);
    tests++;
    if (bus.o_ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: got %b, required 1", bus.o_ovf);
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int c = 0; c < COL; c++) d[c*PW +: PW] = PW'((c << 8) | i);
      step({{(COL-1){1'b1}}, 1'b0}, 1'b0, d);
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int c = 0; c < COL; c++) want[c*PW +: PW] = PW'((c << 8) | i);
      step('0, 1'b1, '0);
      tests++;
      if (bus.out !== want) begin
        fails++;
        $display("FAIL full_order row %0d: got %h, required %h", i, bus.out, want);
      end
    end
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_ovf !== 1'b1) begin
      fails++;
      $display("FAIL drained: valid=%b ovf=%b, required 0/1", bus.o_valid, bus.o_ovf);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) step('1, 1'b0, rand_row());
    for (int k = 0; k < 200; k++) begin
      step('1, 1'b1, rand_row());
      tests++;
      if (bus.out !== exp_out || bus.o_valid !== 1'b1 || bus.o_full !== 1'b0) begin
        fails++;
        $display("FAIL stream row %0d: out=%h valid=%b full=%b, required %h/1/0",
                 k, bus.out, bus.o_valid, bus.o_full, exp_out);
      end
    end
  endtask

  task automatic test_empty_column();
    logic [BW-1:0] held;
    do_reset();
    step('1, 1'b0, rand_row());
    step('1, 1'b0, rand_row());
    step(8'hF7, 1'b0, rand_row());
    step('0, 1'b1, '0);
    step('0, 1'b1, '0);
    held = exp_out;
    step('0, 1'b1, '0);
    tests++;
    if (bus.out !== held || bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL empty_rd: out=%h valid=%b, required %h/0", bus.out, bus.o_valid, held);
    end
    step(8'h08, 1'b0, rand_row());
    step('0, 1'b1, '0);
    tests++;
    if (bus.out !== exp_out) begin
      fails++;
      $display("FAIL aligned_row: got %h, required %h", bus.out, exp_out);
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step('1, 1'b0, rand_row());
    step(COL'(1), 1'b1, rand_row());
    tests++;
    if (bus.o_ovf !== 1'b0 || bus.o_full !== 1'b1 || bus.out !== exp_out) begin
      fails++;
      $display("FAIL full_rw: ovf=%b full=%b out=%h, required 0/1/%h",
               bus.o_ovf, bus.o_full, bus.out, exp_out);
    end
    for (int i = 0; i < DEPTH; i++) step('0, 1'b1, '0);
    tests++;
    if (bus.out !== exp_out || bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_rw_tail: out=%h valid=%b, required %h/0", bus.out, bus.o_valid, exp_out);
    end
  endtask

  task automatic test_mid_reset();
    logic [BW-1:0] fresh;
    do_reset();
    for (int i = 0; i < 5; i++) step('1, 1'b0, rand_row());
    step('0, 1'b1, '0);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.o_valid !== 1'b0 || bus.out !== '0 || bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: valid=%b out=%h ready=%b, required 0/0/1",
               bus.o_valid, bus.out, bus.o_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    fresh = rand_row();
    step('1, 1'b0, fresh);
    step('0, 1'b1, '0);
    tests++;
    if (bus.out !== fresh) begin
      fails++;
      $display("FAIL post_reset_row: got %h, required %h", bus.out, fresh);
    end
  endtask

  task automatic test_random();
    logic [COL-1:0] w;
    logic           r;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      w = COL'($urandom);
      if (k < 250)      r = ($urandom_range(0, 7) == 0);
      else if (k < 400) r = ($urandom_range(0, 1) == 0);
      else              r = ($urandom_range(0, 3) != 0);
      step(w, r, rand_row());
      tests++;
      if (bus.out !== exp_out || bus.o_valid !== m_valid() || bus.o_full !== m_full() ||
          bus.o_ready !== !m_full() || bus.o_ovf !== exp_ovf) begin
        fails++;
        $display("FAIL random cyc %0d: out=%h v=%b f=%b r=%b o=%b, required %h/%b/%b/%b/%b",
                 k, bus.out, bus.o_valid, bus.o_full, bus.o_ready, bus.o_ovf,
                 exp_out, m_valid(), m_full(), !m_full(), exp_ovf);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    bus.wr = '0;
    bus.rd = 1'b0;
    bus.in = '0;
    @(negedge clk);
    test_reset();
    test_skewed_fill();
    test_full_ovf();
    test_back_to_back();
    test_empty_column();
    test_full_rw();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
